ascii_csv_parser: RTL and testbench

ASCII_CSV_PARSER -- requirements
Module: ascii_csv_parser

---
 rtl/ascii_csv_parser_pkg.sv | 37 +++
 rtl/ascii_csv_parser_dec_accum.sv | 42 ++++
 rtl/ascii_csv_parser.sv | 147 ++++++++++++++
 tb/tb_ascii_csv_parser.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_csv_parser_pkg.sv
// Shared types and character constants for the ASCII "a,b@" operand frame parser.
package ascii_csv_parser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [7:0] CH_ZERO  = 8'd48;
    localparam logic [7:0] CH_NINE  = 8'd57;
    localparam logic [7:0] CH_COMMA = 8'd44;
    localparam logic [7:0] CH_TERM  = 8'd64;
    localparam logic [7:0] CH_LF    = 8'd10;
    localparam logic [7:0] CH_CR    = 8'd13;
    localparam logic [7:0] CH_SPACE = 8'd32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIELD_A,
        S_FIELD_B,
        S_DISCARD
    } state_t;

    typedef enum logic [2:0] {
        C_DIGIT,
        C_COMMA,
        C_TERM,
        C_IGNORE,
        C_ILLEGAL
    } char_class_t;

    function automatic char_class_t classify(input logic [7:0] b);
        if (b >= CH_ZERO && b <= CH_NINE)                return C_DIGIT;
        else if (b == CH_COMMA)                          return C_COMMA;
        else if (b == CH_TERM)                           return C_TERM;
        else if (b == CH_LF || b == CH_CR || b == CH_SPACE) return C_IGNORE;
        else                                             return C_ILLEGAL;
    endfunction

endpackage

// File: rtl/ascii_csv_parser_dec_accum.sv
// Decimal field accumulator: acc*10+digit via shifts, sticky overflow, has-digit flag.
module dec_accum #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_digit,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic             overflow,
    output logic             has_digit
);

    localparam int unsigned WW = WIDTH + 4;

    logic [WIDTH-1:0] w_base;
    logic             w_base_ovf;
    logic [WW-1:0]    w_wide;

    // A clear together with a load starts a fresh field seeded with the digit.
    assign w_base     = clear ? '0 : value;
    assign w_base_ovf = clear ? 1'b0 : overflow;
    assign w_wide     = (WW'(w_base) << 3) + (WW'(w_base) << 1) + WW'(digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value     <= '0;
            overflow  <= 1'b0;
            has_digit <= 1'b0;
        end else if (load_digit) begin
            value     <= w_wide[WIDTH-1:0];
            overflow  <= w_base_ovf | (|w_wide[WW-1:WIDTH]);
            has_digit <= 1'b1;
        end else if (clear) begin
            value     <= '0;
            overflow  <= 1'b0;
            has_digit <= 1'b0;
        end
    end

endmodule

// File: rtl/ascii_csv_parser.sv
// Parses UART bytes of the form "<dec>,<dec>@" into op_a/op_b with valid/error pulses.
module ascii_csv_parser
    import ascii_csv_parser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             busy
);

    state_t           r_state;
    logic             r_rx_prev;
    logic             r_first;
    logic [WIDTH-1:0] r_a_hold;
    logic             r_ovf_a;

    state_t           w_state_nxt;
    char_class_t      w_cls;
    logic             w_accept;
    logic             w_acc_clear;
    logic             w_acc_load;
    logic             w_hold_load;
    logic             w_valid_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_acc_value;
    logic             w_acc_ovf;
    logic             w_acc_has;

    // r_first blocks an accept on the first clock after reset release.
    assign w_accept = rx_ready & ~r_rx_prev & ~r_first;
    assign w_cls    = classify(rx_data);

    dec_accum #(.WIDTH(WIDTH)) u_dec_accum (
        .clk        (clk),
        .rst_n      (reset),
        .clear      (w_acc_clear),
        .load_digit (w_acc_load),
        .digit      (4'(rx_data - CH_ZERO)),
        .value      (w_acc_value),
        .overflow   (w_acc_ovf),
        .has_digit  (w_acc_has)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_clear = 1'b0;
        w_acc_load  = 1'b0;
        w_hold_load = 1'b0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cls == C_DIGIT) begin
                        w_acc_clear = 1'b1;
                        w_acc_load  = 1'b1;
                        w_state_nxt = S_FIELD_A;
                    end else if (w_cls != C_IGNORE) begin
                        w_state_nxt = S_DISCARD;
                    end
                end
                S_FIELD_A: begin
                    case (w_cls)
                        C_DIGIT:  w_acc_load = 1'b1;
                        C_COMMA: begin
                            if (w_acc_has) begin
                                w_hold_load = 1'b1;
                                w_acc_clear = 1'b1;
                                w_state_nxt = S_FIELD_B;
                            end else begin
                                w_state_nxt = S_DISCARD;
                            end
                        end
                        C_TERM: begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                        C_IGNORE: ;
                        default:  w_state_nxt = S_DISCARD;
                    endcase
                end
                S_FIELD_B: begin
                    case (w_cls)
                        C_DIGIT:  w_acc_load = 1'b1;
                        C_TERM: begin
                            // Overflow in either field invalidates the whole frame.
                            if (w_acc_has && !w_acc_ovf && !r_ovf_a) w_valid_nxt = 1'b1;
                            else                                     w_err_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                        C_COMMA: begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                        C_IGNORE: ;
                        default:  w_state_nxt = S_DISCARD;
                    endcase
                end
                S_DISCARD: begin
                    if (w_cls == C_TERM) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rx_prev   <= 1'b0;
            r_first     <= 1'b1;
            r_a_hold    <= '0;
            r_ovf_a     <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_rx_prev   <= rx_ready;
            r_first     <= 1'b0;
            r_state     <= w_state_nxt;
            busy        <= (w_state_nxt != S_IDLE);
            frame_valid <= w_valid_nxt;
            frame_err   <= w_err_nxt;
            if (w_hold_load) begin
                r_a_hold <= w_acc_value;
                r_ovf_a  <= w_acc_ovf;
            end
            if (w_valid_nxt) begin
                op_a <= r_a_hold;
                op_b <= w_acc_value;
            end
        end
    end

endmodule

// File: tb/tb_ascii_csv_parser.sv
// Bench for ascii_csv_parser: directed frame table, reset corner cases, random frames vs model.
module tb_ascii_csv_parser;

    localparam int unsigned WIDTH = 16;
    localparam longint MAXV = (64'd1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             frame_valid;
    logic             frame_err;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_err    = 0;

    ascii_csv_parser #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .op_a        (op_a),
        .op_b        (op_b),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse counters and mutual-exclusion check, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_valid) n_valid++;
            if (frame_err)   n_err++;
            if (frame_valid && frame_err) begin
                checks++;
                failures++;
                $display("FAIL pulse_overlap: valid=1 err=1 expected not both");
            end
        end
    end

    // Behavioural model: a frame is "number , number @" with whitespace skipped.
    int     m_mode;  // 0 waiting, 1 first number, 2 second number, 3 skipping to '@'
    longint m_acc, m_hold, m_a, m_b;
    bit     m_has, m_ovf, m_ovf_a;

    function automatic void model_reset();
        m_mode = 0; m_acc = 0; m_hold = 0; m_a = 0; m_b = 0;
        m_has = 0; m_ovf = 0; m_ovf_a = 0;
    endfunction

    function automatic void model_digit(input int d);
        longint v;
        v = m_acc * 10 + d;
        if (v > MAXV) m_ovf = 1;
        m_acc = v % (MAXV + 1);
        m_has = 1;
    endfunction

    // Returns 0 = no pulse, 1 = frame_valid, 2 = frame_err.
    function automatic int model_step(input logic [7:0] b);
        bit dig;
        dig = (b >= 8'd48 && b <= 8'd57);
        if (b == 8'd10 || b == 8'd13 || b == 8'd32) return 0;
        case (m_mode)
            0: begin
                if (dig) begin
                    m_acc = 0; m_has = 0; m_ovf = 0;
                    model_digit(int'(b) - 48);
                    m_mode = 1;
                end else m_mode = 3;
            end
            1: begin
                if (dig) model_digit(int'(b) - 48);
                else if (b == 8'd44) begin
                    if (m_has) begin
                        m_hold = m_acc; m_ovf_a = m_ovf;
                        m_acc = 0; m_has = 0; m_ovf = 0;
                        m_mode = 2;
                    end else m_mode = 3;
                end else if (b == 8'd64) begin
                    m_mode = 0;
                    return 2;
                end else m_mode = 3;
            end
            2: begin
                if (dig) model_digit(int'(b) - 48);
                else if (b == 8'd64) begin
                    m_mode = 0;
                    if (m_has && !m_ovf && !m_ovf_a) begin
                        m_a = m_hold; m_b = m_acc;
                        return 1;
                    end
                    return 2;
                end else if (b == 8'd44) begin
                    m_mode = 0;
                    return 2;
                end else m_mode = 3;
            end
            default: begin
                if (b == 8'd64) begin
                    m_mode = 0;
                    return 2;
                end
            end
        endcase
        return 0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold);
        int ev;
        ev = model_step(b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        check("byte_valid", longint'(frame_valid), longint'(ev == 1));
        check("byte_err",   longint'(frame_err),   longint'(ev == 2));
        check("byte_op_a",  longint'(op_a), m_a);
        check("byte_op_b",  longint'(op_b), m_b);
        check("byte_busy",  longint'(busy), longint'(m_mode != 0));
        for (int i = 1; i < hold; i++) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], hold);
    endtask

    typedef struct {
        string  s;
        int     hold;
        longint exp_a;
        longint exp_b;
        int     exp_nv;
        int     exp_ne;
    } vec_t;

    vec_t vecs[7];

    initial begin
        string  fs;
        string  junk;
        int     nv0, ne0;

        vecs[0] = '{"123,45@",        4,  123, 45, 1, 0};
        vecs[1] = '{"7,65536@",       3,  123, 45, 0, 1};
        vecs[2] = '{",5@",            2,  123, 45, 0, 1};
        vecs[3] = '{"9,0@",           2,  9,   0,  1, 0};
        vecs[4] = '{"1x2,3@",         3,  9,   0,  0, 1};
        vecs[5] = '{"1 2,\0153@",     2,  12,  3,  1, 0};
        vecs[6] = '{"8,1@",           50, 8,   1,  1, 0};

        reset    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_op_a",  longint'(op_a), 0);
        check("rst_op_b",  longint'(op_b), 0);
        check("rst_busy",  longint'(busy), 0);
        check("rst_valid", longint'(frame_valid), 0);
        check("rst_err",   longint'(frame_err), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[k]) begin
            nv0 = n_valid;
            ne0 = n_err;
            send_str(vecs[k].s, vecs[k].hold);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_op_a", k), longint'(op_a), vecs[k].exp_a);
            check($sformatf("vec%0d_op_b", k), longint'(op_b), vecs[k].exp_b);
            check($sformatf("vec%0d_nvalid", k), longint'(n_valid - nv0), longint'(vecs[k].exp_nv));
            check($sformatf("vec%0d_nerr", k),   longint'(n_err - ne0),   longint'(vecs[k].exp_ne));
        end

        // Reset mid-frame, then release while a byte is already being presented.
        send_str("12,", 2);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_op_a", longint'(op_a), 0);
        check("midrst_op_b", longint'(op_b), 0);
        @(negedge clk);
        rx_data  = 8'd57;
        rx_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("release_busy", longint'(busy), 0);
        rx_ready = 1'b0;
        @(negedge clk);
        nv0 = n_valid;
        send_str("4,5@", 2);
        repeat (2) @(negedge clk);
        check("post_rst_op_a", longint'(op_a), 4);
        check("post_rst_op_b", longint'(op_b), 5);
        check("post_rst_nvalid", longint'(n_valid - nv0), 1);

        // Random frames, some near the overflow limit, some corrupted.
        junk = "x,@ \n5";
        for (int f = 0; f < 150; f++) begin
            int a, b;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60000, 70000))
                                            : int'($urandom_range(0, 999));
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60000, 70000))
                                            : int'($urandom_range(0, 999));
            fs = $sformatf("%0d,%0d@", a, b);
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = int'($urandom_range(0, fs.len() - 1));
                fs[p] = junk[$urandom_range(0, junk.len() - 1)];
            end
            if ($urandom_range(0, 3) == 0) fs = {" ", fs};
            send_str(fs, int'($urandom_range(1, 4)));
        end
        repeat (3) @(negedge clk);
        check("final_op_a", longint'(op_a), m_a);
        check("final_op_b", longint'(op_b), m_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
